// File: rtl/dispatcher_pkg.sv
// Shared constants for the issue stage: op-type codes, RV32I opcodes and
// default widths for ROB indices and op-type codes.
package dispatcher_pkg;

  localparam int DEF_ROB_SIZE_LOG = 4;
  localparam int DEF_OP_SIZE_LOG  = 6;

  typedef enum logic [5:0] {
    OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_ALT = 7'b0100000;

endpackage

// File: rtl/dispatcher_inst_decoder.sv
// Combinational RV32I decoder: op type, register fields, formatted immediate,
// routing (RS or SLB), source/destination usage and illegal-encoding flag.
module inst_decoder
  import dispatcher_pkg::*;
(
  input  logic [31:0] inst,
  output op_t         op,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        to_slb,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        writes_rd,
  output logic        illegal
);

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, sh_imm;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];
  assign rd  = inst[11:7];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];

  assign i_imm  = {{20{inst[31]}}, inst[31:20]};
  assign s_imm  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign b_imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm  = {inst[31:12], 12'd0};
  assign j_imm  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign sh_imm = {27'd0, inst[24:20]};

  always_comb begin
    op        = OP_NOP;
    imm       = '0;
    to_slb    = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (opc)
      OPC_LUI:   begin op = OP_LUI;   imm = u_imm; writes_rd = 1'b1; end
      OPC_AUIPC: begin op = OP_AUIPC; imm = u_imm; writes_rd = 1'b1; end
      OPC_JAL:   begin op = OP_JAL;   imm = j_imm; writes_rd = 1'b1; end
      OPC_JALR: begin
        op = OP_JALR; imm = i_imm; uses_rs1 = 1'b1; writes_rd = 1'b1;
        illegal = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        imm = b_imm; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        case (f3)
          3'd0:    op = OP_BEQ;
          3'd1:    op = OP_BNE;
          3'd4:    op = OP_BLT;
          3'd5:    op = OP_BGE;
          3'd6:    op = OP_BLTU;
          3'd7:    op = OP_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        imm = i_imm; uses_rs1 = 1'b1; writes_rd = 1'b1; to_slb = 1'b1;
        case (f3)
          3'd0:    op = OP_LB;
          3'd1:    op = OP_LH;
          3'd2:    op = OP_LW;
          3'd4:    op = OP_LBU;
          3'd5:    op = OP_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        imm = s_imm; uses_rs1 = 1'b1; uses_rs2 = 1'b1; to_slb = 1'b1;
        case (f3)
          3'd0:    op = OP_SB;
          3'd1:    op = OP_SH;
          3'd2:    op = OP_SW;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        imm = i_imm; uses_rs1 = 1'b1; writes_rd = 1'b1;
        case (f3)
          3'd0: op = OP_ADDI;
          3'd2: op = OP_SLTI;
          3'd3: op = OP_SLTIU;
          3'd4: op = OP_XORI;
          3'd6: op = OP_ORI;
          3'd7: op = OP_ANDI;
          3'd1: begin op = OP_SLLI; imm = sh_imm; illegal = (f7 != 7'd0); end
          3'd5: begin
            op = f7[5] ? OP_SRAI : OP_SRLI; imm = sh_imm;
            illegal = (f7 != 7'd0) && (f7 != F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1;
        // only ADD/SUB and SRL/SRA accept the alternate funct7
        illegal = (f7 != 7'd0) && !((f7 == F7_ALT) && (f3 == 3'd0 || f3 == 3'd5));
        case (f3)
          3'd0: op = f7[5] ? OP_SUB : OP_ADD;
          3'd1: op = OP_SLL;
          3'd2: op = OP_SLT;
          3'd3: op = OP_SLTU;
          3'd4: op = OP_XOR;
          3'd5: op = f7[5] ? OP_SRA : OP_SRL;
          3'd6: op = OP_OR;
          3'd7: op = OP_AND;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dispatcher.sv
// In-order issue stage: pops one instruction per cycle, resolves operands from
// regfile/ROB/CDBs, allocates the ROB tail and emits a registered issue packet.
module dispatcher
  import dispatcher_pkg::*;
#(
  parameter int ROB_SIZE_LOG = DEF_ROB_SIZE_LOG,
  parameter int OP_SIZE_LOG  = DEF_OP_SIZE_LOG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    iq_valid,
  input  logic [31:0]             iq_inst,
  input  logic [31:0]             iq_pc,
  output logic                    iq_pop,
  input  logic                    RS_next_full,
  input  logic                    SLB_next_full,
  input  logic                    ROB_next_full,
  input  logic [ROB_SIZE_LOG-1:0] rob_tail,
  output logic [4:0]              rs1_idx,
  output logic [4:0]              rs2_idx,
  input  logic                    rs1_busy,
  input  logic                    rs2_busy,
  input  logic [ROB_SIZE_LOG-1:0] rs1_robid,
  input  logic [ROB_SIZE_LOG-1:0] rs2_robid,
  input  logic [31:0]             rs1_val,
  input  logic [31:0]             rs2_val,
  output logic [ROB_SIZE_LOG-1:0] rob_q1,
  output logic [ROB_SIZE_LOG-1:0] rob_q2,
  input  logic                    rob_r1,
  input  logic                    rob_r2,
  input  logic [31:0]             rob_v1,
  input  logic [31:0]             rob_v2,
  input  logic                    ALU_valid,
  input  logic [ROB_SIZE_LOG-1:0] ALU_robid,
  input  logic [31:0]             ALU_value,
  input  logic                    SLB_load_valid,
  input  logic [ROB_SIZE_LOG-1:0] SLB_load_robid,
  input  logic [31:0]             SLB_load_value,
  input  logic                    pred_fail_flag,
  output logic                    rs_issue_valid,
  output logic                    slb_issue_valid,
  output logic                    rob_issue_valid,
  output logic [OP_SIZE_LOG-1:0]  issue_op_type,
  output logic [31:0]             issue_vj,
  output logic [31:0]             issue_vk,
  output logic [31:0]             issue_imm,
  output logic [31:0]             issue_curPc,
  output logic [ROB_SIZE_LOG-1:0] issue_qj,
  output logic [ROB_SIZE_LOG-1:0] issue_qk,
  output logic [ROB_SIZE_LOG-1:0] issue_robid,
  output logic                    issue_rj,
  output logic                    issue_rk,
  output logic [4:0]              issue_rd,
  output logic                    rename_valid,
  output logic [4:0]              rename_rd,
  output logic [ROB_SIZE_LOG-1:0] rename_robid
);

  op_t                    dec_op;
  logic [4:0]             dec_rd;
  logic [31:0]            dec_imm;
  logic                   dec_slb, dec_use1, dec_use2, dec_wrd, dec_ill;
  logic                   fire, issue, do_rename;
  logic                   nx_rj, nx_rk;
  logic [ROB_SIZE_LOG-1:0] nx_qj, nx_qk;
  logic [31:0]            nx_vj, nx_vk;

  inst_decoder u_dec (
    .inst      (iq_inst),
    .op        (dec_op),
    .rd        (dec_rd),
    .rs1       (rs1_idx),
    .rs2       (rs2_idx),
    .imm       (dec_imm),
    .to_slb    (dec_slb),
    .uses_rs1  (dec_use1),
    .uses_rs2  (dec_use2),
    .writes_rd (dec_wrd),
    .illegal   (dec_ill)
  );

  assign fire      = iq_valid & rdy & ~(RS_next_full | SLB_next_full | ROB_next_full) & ~pred_fail_flag;
  assign iq_pop    = fire;
  assign issue     = fire & ~dec_ill;
  assign do_rename = issue & dec_wrd & (dec_rd != 5'd0);
  assign rob_q1    = rs1_robid;
  assign rob_q2    = rs2_robid;

  // Returns {ready, tag, value}; unused sources and x0 are always ready with value 0.
  function automatic logic [ROB_SIZE_LOG+32:0] resolve(
      input logic used, input logic [4:0] idx, input logic busy,
      input logic [ROB_SIZE_LOG-1:0] robid, input logic [31:0] val,
      input logic rob_r, input logic [31:0] rob_v);
    logic                    r;
    logic [ROB_SIZE_LOG-1:0] q;
    logic [31:0]             v;
    r = 1'b1;
    q = '0;
    v = '0;
    if (used && idx != 5'd0) begin
      if (!busy)                                         v = val;
      else if (rob_r)                                    v = rob_v;
      else if (ALU_valid && ALU_robid == robid)           v = ALU_value;
      else if (SLB_load_valid && SLB_load_robid == robid) v = SLB_load_value;
      else begin
        r = 1'b0;
        q = robid;
      end
    end
    return {r, q, v};
  endfunction

  always_comb begin
    {nx_rj, nx_qj, nx_vj} = resolve(dec_use1, rs1_idx, rs1_busy, rs1_robid, rs1_val, rob_r1, rob_v1);
    {nx_rk, nx_qk, nx_vk} = resolve(dec_use2, rs2_idx, rs2_busy, rs2_robid, rs2_val, rob_r2, rob_v2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_issue_valid  <= 1'b0;
      slb_issue_valid <= 1'b0;
      rob_issue_valid <= 1'b0;
      rename_valid    <= 1'b0;
      issue_op_type   <= '0;
      issue_vj        <= '0;
      issue_vk        <= '0;
      issue_imm       <= '0;
      issue_curPc     <= '0;
      issue_qj        <= '0;
      issue_qk        <= '0;
      issue_robid     <= '0;
      issue_rj        <= 1'b0;
      issue_rk        <= 1'b0;
      issue_rd        <= '0;
      rename_rd       <= '0;
      rename_robid    <= '0;
    end else if (rdy) begin
      rs_issue_valid  <= issue & ~dec_slb;
      slb_issue_valid <= issue & dec_slb;
      rob_issue_valid <= issue;
      rename_valid    <= do_rename;
      if (issue) begin
        issue_op_type <= OP_SIZE_LOG'(dec_op);
        issue_vj      <= nx_vj;
        issue_vk      <= nx_vk;
        issue_qj      <= nx_qj;
        issue_qk      <= nx_qk;
        issue_rj      <= nx_rj;
        issue_rk      <= nx_rk;
        issue_imm     <= dec_imm;
        issue_curPc   <= iq_pc;
        issue_robid   <= rob_tail;
        issue_rd      <= dec_wrd ? dec_rd : 5'd0;
      end
      if (do_rename) begin
        rename_rd    <= dec_rd;
        rename_robid <= rob_tail;
      end
    end
  end

endmodule
